// File: rtl/mips_run_ctrl_pkg.sv
// Shared types and constants for the MIPS run controller: run states,
// trace entry layout and the write-filter helper.
package mips_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_t;

    // beq $0,$0,-1: the core spins on itself once the program finishes
    localparam logic [31:0] HALT_INSTR_DEF = 32'h1000_ffff;

    localparam int TRACE_W = 69;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trace_entry_t;

    // $0 is hard-wired, so writes to it carry no information for the checker
    function automatic logic is_traced_write(input logic we, input logic [4:0] addr);
        return we && (addr != 5'd0);
    endfunction

endpackage

// File: rtl/mips_run_ctrl_trace_fifo.sv
// Synchronous trace FIFO with a registered head entry (zero when empty),
// simultaneous push/pop and a drop pulse when a push hits a full queue.
module trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full_s, empty_s, do_push_s, do_pop_s;

    // Pointer/count update and next head selection
    always_comb begin
        full_s    = (count_q == CNT_W'(DEPTH));
        empty_s   = (count_q == {CNT_W{1'b0}});
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
        drop      = push && !do_push_s;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + 1'b1;
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q;
        end
        valid_d = (count_d != {CNT_W{1'b0}});
        // The slot being written this edge is not in mem_q yet, so forward it
        if (!valid_d) begin
            head_d = {WIDTH{1'b0}};
        end else if (do_push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control and head registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            head_q   <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage; contents are meaningless until a pointer covers them
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_valid = valid_q;
    assign head_data  = head_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for MIPS bring-up: sequences core reset, counts RUN cycles,
// detects the jump-to-self halt, enforces a timeout and traces GRF writes.
module mips_run_ctrl
    import mips_run_ctrl_pkg::*;
#(
    parameter int          RST_CYCLES  = 4,
    parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEF,
    parameter int          HALT_REPEAT = 3,
    parameter int          TIMEOUT     = 100000,
    parameter int          CNT_W       = 32,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             grf_we,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wdata,
    output logic             core_reset,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic             done,
    output logic             timed_out,
    output logic             overflow,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int HALT_W = $clog2(HALT_REPEAT + 1);

    run_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HALT_W-1:0] halt_cnt_q, halt_cnt_d;
    logic [31:0]      prev_pc_q, prev_pc_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic             core_reset_q, core_reset_d;
    logic             done_q, done_d;
    logic             timed_out_q, timed_out_d;
    logic             overflow_q, overflow_d;
    logic             halt_hit_s, timeout_hit_s, push_s, pop_s, drop_s;
    trace_entry_t     push_entry_s, head_s;

    // Run sequencing, halt/timeout detection and trace push qualification
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        halt_cnt_d    = halt_cnt_q;
        cycle_d       = cycle_q;
        prev_pc_d     = pc;
        halt_hit_s    = 1'b0;
        timeout_hit_s = 1'b0;
        push_s        = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = {HOLD_W{1'b0}};
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                push_s = is_traced_write(grf_we, grf_addr);
                // Never exceeds HALT_REPEAT: reaching it leaves RUN
                if (instr == HALT_INSTR) begin
                    if (pc == prev_pc_q) begin
                        halt_cnt_d = halt_cnt_q + 1'b1;
                    end else begin
                        halt_cnt_d = HALT_W'(1);
                    end
                end else begin
                    halt_cnt_d = {HALT_W{1'b0}};
                end
                halt_hit_s    = (halt_cnt_d == HALT_W'(HALT_REPEAT));
                timeout_hit_s = (cycle_q == CNT_W'(TIMEOUT - 1));
                // Count is frozen on the edge that ends the run
                if (halt_hit_s) begin
                    state_d = ST_DONE;
                end else if (timeout_hit_s) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    state_d = ST_RUN;
                    if (cycle_q != {CNT_W{1'b1}}) begin
                        cycle_d = cycle_q + 1'b1;
                    end else begin
                        cycle_d = cycle_q;
                    end
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
        core_reset_d = (state_d != ST_RUN);
        done_d       = (state_d == ST_DONE);
        timed_out_d  = (state_d == ST_TIMEOUT);
        overflow_d   = overflow_q | drop_s;
    end

    // Controller state and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= {HOLD_W{1'b0}};
            halt_cnt_q   <= {HALT_W{1'b0}};
            prev_pc_q    <= 32'd0;
            cycle_q      <= {CNT_W{1'b0}};
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            halt_cnt_q   <= halt_cnt_d;
            prev_pc_q    <= prev_pc_d;
            cycle_q      <= cycle_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            timed_out_q  <= timed_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign push_entry_s = '{pc: pc, addr: grf_addr, data: grf_wdata};
    assign pop_s        = trace_valid & trace_ready;

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .rst        (reset),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .head_valid (trace_valid),
        .head_data  (head_s),
        .drop       (drop_s)
    );

    assign trace_pc    = head_s.pc;
    assign trace_addr  = head_s.addr;
    assign trace_data  = head_s.data;
    assign core_reset  = core_reset_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign overflow    = overflow_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed and randomized checks of mips_run_ctrl against a queue-based
// behavioural model of the run rules and the trace FIFO.
module tb_mips_run_ctrl;

    localparam int          RST_CYCLES  = 4;
    localparam int          HALT_REPEAT = 3;
    localparam int          TIMEOUT     = 20;
    localparam int          CNT_W       = 32;
    localparam int          DEPTH       = 8;
    localparam logic [31:0] HALT        = 32'h1000_ffff;
    localparam logic [31:0] NOP         = 32'h0000_0000;

    localparam int PH_HOLD = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;
    localparam int PH_TO   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      pc, instr, grf_wdata;
    logic             grf_we, trace_ready;
    logic [4:0]       grf_addr;
    logic             core_reset, trace_valid, done, timed_out, overflow;
    logic [31:0]      trace_pc, trace_data;
    logic [4:0]       trace_addr;
    logic [CNT_W-1:0] cycle_count;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .HALT_INSTR  (HALT),
        .HALT_REPEAT (HALT_REPEAT),
        .TIMEOUT     (TIMEOUT),
        .CNT_W       (CNT_W),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instr       (instr),
        .grf_we      (grf_we),
        .grf_addr    (grf_addr),
        .grf_wdata   (grf_wdata),
        .core_reset  (core_reset),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .done        (done),
        .timed_out   (timed_out),
        .overflow    (overflow),
        .cycle_count (cycle_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    int               m_phase, m_hold, m_streak;
    logic [CNT_W-1:0] m_cycles;
    logic [31:0]      m_prev_pc;
    logic [68:0]      m_q[$];
    bit               m_ovf;

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_HOLD;
        m_hold    = 0;
        m_streak  = 0;
        m_cycles  = '0;
        m_prev_pc = 32'd0;
        m_q.delete();
        m_ovf     = 1'b0;
    endtask

    // What one rising edge does, given the inputs currently applied
    task automatic model_edge();
        bit pop, push;
        pop  = (m_q.size() > 0) && trace_ready;
        push = (m_phase == PH_RUN) && grf_we && (grf_addr != 5'd0);
        if (m_phase == PH_HOLD) begin
            m_hold++;
            if (m_hold == RST_CYCLES) m_phase = PH_RUN;
        end else if (m_phase == PH_RUN) begin
            if (instr == HALT) m_streak = (pc == m_prev_pc) ? m_streak + 1 : 1;
            else m_streak = 0;
            if (m_streak >= HALT_REPEAT) m_phase = PH_DONE;
            else if (m_cycles == CNT_W'(TIMEOUT - 1)) m_phase = PH_TO;
            else if (m_cycles != '1) m_cycles = m_cycles + 1;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back({pc, grf_addr, grf_wdata});
            else m_ovf = 1'b1;
        end
        m_prev_pc = pc;
    endtask

    task automatic check_all();
        logic [68:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 69'd0;
        chk("core_reset",  69'(core_reset),  69'(m_phase != PH_RUN));
        chk("done",        69'(done),        69'(m_phase == PH_DONE));
        chk("timed_out",   69'(timed_out),   69'(m_phase == PH_TO));
        chk("overflow",    69'(overflow),    69'(m_ovf));
        chk("cycle_count", 69'(cycle_count), 69'(m_cycles));
        chk("trace_valid", 69'(trace_valid), 69'(m_q.size() > 0));
        chk("trace_pc",    69'(trace_pc),    69'(head[68:37]));
        chk("trace_addr",  69'(trace_addr),  69'(head[36:32]));
        chk("trace_data",  69'(trace_data),  69'(head[31:0]));
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic [31:0] ins, input logic rdy);
        grf_we = we; grf_addr = a; grf_wdata = d; pc = p; instr = ins; trace_ready = rdy;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic enter_run();
        for (int i = 0; i < 10; i++) begin
            if (!core_reset) break;
            step();
        end
    endtask

    initial begin
        int edges, popped, nc, halt_at, halt_len;
        logic [31:0] pcv;
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 32'h0000_3000, NOP, 1'b0);

        // 1: release timing and first counts
        do_reset();
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            edges++;
            if (!core_reset) break;
        end
        chk("t1_release_edge", 69'(edges), 69'd4);
        chk("t1_count0", 69'(cycle_count), 69'd0);
        step();
        chk("t1_count1", 69'(cycle_count), 69'd1);

        // 2: one traced write, $0 write ignored
        drive(1'b1, 5'd5, 32'h0000_1234, 32'h0000_3000, NOP, 1'b0); step();
        drive(1'b1, 5'd0, 32'h0000_00ff, 32'h0000_3004, NOP, 1'b0); step();
        drive(1'b0, 5'd0, 32'd0, 32'h0000_3008, NOP, 1'b0); step();
        chk("t2_valid", 69'(trace_valid), 69'd1);
        chk("t2_entry", 69'({trace_pc, trace_addr, trace_data}),
            {32'h0000_3000, 5'd5, 32'h0000_1234});
        drive(1'b0, 5'd0, 32'd0, 32'h0000_300c, NOP, 1'b1); step();
        chk("t2_single", 69'(trace_valid), 69'd0);

        // 3: halt idiom
        drive(1'b0, 5'd0, 32'd0, 32'h0000_3010, HALT, 1'b1);
        step(); step();
        chk("t3_not_yet", 69'(done), 69'd0);
        step();
        chk("t3_done", 69'(done), 69'd1);
        chk("t3_core_reset", 69'(core_reset), 69'd1);
        chk("t3_count", 69'(cycle_count), 69'd7);
        drive(1'b1, 5'd3, 32'h0000_0077, 32'h0000_3014, NOP, 1'b1); step(); step();

        // 4: timeout
        do_reset();
        pcv = 32'h0000_4000;
        for (int i = 0; i < 40; i++) begin
            if (timed_out) break;
            drive(1'b0, 5'd0, 32'd0, pcv, NOP, 1'b1); pcv += 32'd4;
            step();
        end
        chk("t4_timed_out", 69'(timed_out), 69'd1);
        chk("t4_done", 69'(done), 69'd0);
        chk("t4_count", 69'(cycle_count), 69'd19);

        // 5a: nine writes into eight slots
        do_reset();
        enter_run();
        pcv = 32'h0000_5000;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 5'(i), 32'hA000_0000 + 32'(i), pcv, NOP, 1'b0); pcv += 32'd4;
            step();
        end
        chk("t5_overflow", 69'(overflow), 69'd1);
        popped = 0;
        drive(1'b0, 5'd0, 32'd0, pcv, NOP, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (trace_valid) popped++;
            step();
        end
        chk("t5_kept", 69'(popped), 69'd8);

        // 5b: full with simultaneous push and pop
        do_reset();
        enter_run();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'(i), 32'hB000_0000 + 32'(i), pcv, NOP, 1'b0); pcv += 32'd4;
            step();
        end
        drive(1'b1, 5'd9, 32'hB000_0009, pcv, NOP, 1'b1); step();
        chk("t5_no_drop", 69'(overflow), 69'd0);
        popped = 0;
        drive(1'b0, 5'd0, 32'd0, pcv, NOP, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (trace_valid) popped++;
            step();
        end
        chk("t5_full_count", 69'(popped), 69'd8);

        // 6: reset mid-run discards queued entries
        do_reset();
        enter_run();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'(i + 10), 32'(i), pcv, NOP, 1'b0); pcv += 32'd4;
            step();
        end
        chk("t6_queued", 69'(trace_valid), 69'd1);
        do_reset();
        chk("t6_valid", 69'(trace_valid), 69'd0);
        chk("t6_core_reset", 69'(core_reset), 69'd1);
        step();

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            do_reset();
            nc       = $urandom_range(8, 32);
            halt_at  = ($urandom_range(0, 2) != 0) ? $urandom_range(0, nc) : 1000;
            halt_len = $urandom_range(1, 4);
            pcv      = 32'h0000_3000;
            for (int c = 0; c < nc; c++) begin
                logic [31:0] ins;
                if (c >= halt_at && c < halt_at + halt_len) begin
                    ins = HALT;
                end else begin
                    ins = $urandom();
                    if (ins == HALT) ins = NOP;
                    pcv += 32'd4;
                end
                drive(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom()),
                      $urandom(), pcv, ins,
                      (r % 3 == 0) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)));
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
